// File: rtl/alif_config_sequencer_if.sv
// Host configuration byte channel (valid/ready, one byte per accepted beat).
//   cfg_valid : host has a byte on cfg_data
//   cfg_data  : configuration byte
//   cfg_ready : sequencer can take a byte this cycle (combinational)
interface alif_config_sequencer_if;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/alif_config_sequencer.sv
// Configuration and run controller for the ALIF dual-unileak neuron system.
// Collects a NUM_BYTES frame from the host, shifts it MSB-first onto the
// neuron's load_mode/serial_data pins, waits (bounded) for params_ready and
// only then allows the neuron's input_enable.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   cfg_if (slave)      : host byte channel
//   i_abort             : cancel any operation, return to IDLE
//   i_run_req           : host requests neuron operation
//   i_params_ready      : neuron reports parameters loaded
//   o_load_mode         : neuron load_mode
//   o_serial_data       : neuron serial_data
//   o_neuron_enable     : neuron input_enable
//   o_busy              : collecting, shifting or waiting for params_ready
//   o_done              : one-cycle pulse on successful configuration
//   o_err               : sticky params_ready timeout flag
module alif_config_sequencer #(
    parameter int unsigned NUM_BYTES = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    alif_config_sequencer_if.slave   cfg_if,
    input  logic                     i_abort,
    input  logic                     i_run_req,
    input  logic                     i_params_ready,
    output logic                     o_load_mode,
    output logic                     o_serial_data,
    output logic                     o_neuron_enable,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int unsigned FRAME_W = NUM_BYTES * 8;
    localparam int unsigned BYTE_W  = $clog2(NUM_BYTES + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_SHIFT    = 2'd2,
        S_WAIT_RDY = 2'd3
    } state_t;

    state_t               r_state;
    logic [BYTE_W-1:0]    r_byte_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [TMO_W-1:0]     r_tmo;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_configured;
    logic                 r_err;
    logic                 r_load_mode;
    logic                 r_serial_data;
    logic                 r_neuron_enable;
    logic                 r_busy;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [BYTE_W-1:0]    w_byte_cnt_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [TMO_W-1:0]     w_tmo_nxt;
    logic [FRAME_W-1:0]   w_frame_nxt;
    logic                 w_configured_nxt;
    logic                 w_err_nxt;
    logic                 w_success;
    logic                 w_load_mode_nxt;
    logic                 w_serial_nxt;
    logic                 w_neuron_enable_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_cfg_ready;
    logic                 w_accept;

    // Host handshake: bytes only taken while idle/collecting and not aborting
    assign w_cfg_ready      = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && !i_abort;
    assign w_accept         = cfg_if.cfg_valid && w_cfg_ready;
    assign cfg_if.cfg_ready = w_cfg_ready;

    // State and register update
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_byte_cnt      <= '0;
            r_bit           <= '0;
            r_tmo           <= '0;
            r_frame         <= '0;
            r_configured    <= 1'b0;
            r_err           <= 1'b0;
            r_load_mode     <= 1'b0;
            r_serial_data   <= 1'b0;
            r_neuron_enable <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_byte_cnt      <= w_byte_cnt_nxt;
            r_bit           <= w_bit_nxt;
            r_tmo           <= w_tmo_nxt;
            r_frame         <= w_frame_nxt;
            r_configured    <= w_configured_nxt;
            r_err           <= w_err_nxt;
            r_load_mode     <= w_load_mode_nxt;
            r_serial_data   <= w_serial_nxt;
            r_neuron_enable <= w_neuron_enable_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
        end
    end

    // Next-state and datapath
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_bit_nxt        = r_bit;
        w_tmo_nxt        = r_tmo;
        w_frame_nxt      = r_frame;
        w_configured_nxt = r_configured;
        w_err_nxt        = r_err;
        w_success        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_frame_nxt[FRAME_W-1 -: 8] = cfg_if.cfg_data;
                    w_byte_cnt_nxt   = BYTE_W'(1);
                    w_bit_nxt        = '0;
                    w_configured_nxt = 1'b0;
                    w_err_nxt        = 1'b0;
                    w_state_nxt      = (NUM_BYTES == 1) ? S_SHIFT : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    // Slot k occupies the k-th byte from the MSB end
                    for (int k = 0; k < NUM_BYTES; k++) begin
                        if (r_byte_cnt == BYTE_W'(k)) begin
                            w_frame_nxt[FRAME_W-1-8*k -: 8] = cfg_if.cfg_data;
                        end
                    end
                    w_byte_cnt_nxt = r_byte_cnt + BYTE_W'(1);
                    if (r_byte_cnt == BYTE_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_bit == BIT_LAST) begin
                    w_bit_nxt   = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT_RDY;
                end else begin
                    w_bit_nxt = r_bit + BIT_W'(1);
                end
            end
            S_WAIT_RDY: begin
                // params_ready wins over the final timeout cycle
                if (i_params_ready) begin
                    w_success        = 1'b1;
                    w_configured_nxt = 1'b1;
                    w_byte_cnt_nxt   = '0;
                    w_tmo_nxt        = '0;
                    w_state_nxt      = S_IDLE;
                end else if (r_tmo == TMO_LAST) begin
                    w_err_nxt        = 1'b1;
                    w_configured_nxt = 1'b0;
                    w_byte_cnt_nxt   = '0;
                    w_tmo_nxt        = '0;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything except the sticky error flag
        if (i_abort) begin
            w_state_nxt      = S_IDLE;
            w_byte_cnt_nxt   = '0;
            w_bit_nxt        = '0;
            w_tmo_nxt        = '0;
            w_configured_nxt = 1'b0;
            w_success        = 1'b0;
        end
    end

    // Output decode, registered so pins line up with the state they describe
    always_comb begin
        w_load_mode_nxt     = (w_state_nxt == S_SHIFT);
        w_serial_nxt        = 1'b0;
        if (w_load_mode_nxt) begin
            w_serial_nxt = w_frame_nxt[BIT_LAST - w_bit_nxt];
        end
        w_busy_nxt          = (w_state_nxt != S_IDLE);
        w_done_nxt          = w_success;
        w_neuron_enable_nxt = i_run_req && r_configured && (r_state == S_IDLE) && !i_abort;
    end

    assign o_load_mode     = r_load_mode;
    assign o_serial_data   = r_serial_data;
    assign o_neuron_enable = r_neuron_enable;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;

endmodule

// File: tb/tb_alif_config_sequencer.sv
// Directed bench for alif_config_sequencer (NUM_BYTES=4, TIMEOUT=64).
module tb_alif_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic abort;
    logic run_req;
    logic params_ready;
    logic load_mode;
    logic serial_data;
    logic neuron_enable;
    logic busy;
    logic done;
    logic err;

    int errors = 0;
    int checks = 0;

    alif_config_sequencer_if cfg_if();

    alif_config_sequencer #(
        .NUM_BYTES (4),
        .TIMEOUT   (64)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .cfg_if          (cfg_if),
        .i_abort         (abort),
        .i_run_req       (run_req),
        .i_params_ready  (params_ready),
        .o_load_mode     (load_mode),
        .o_serial_data   (serial_data),
        .o_neuron_enable (neuron_enable),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the top n bytes of frame back-to-back, one per cycle
    task automatic send_bytes(input logic [31:0] frame, input int n,
                              input bit hold_valid, input logic [7:0] hold_data);
        for (int i = 0; i < n; i++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = frame[31-8*i -: 8];
            tick();
        end
        if (hold_valid) begin
            cfg_if.cfg_data = hold_data;
        end else begin
            cfg_if.cfg_valid = 1'b0;
        end
    endtask

    // Record the shifted stream; returns at the first cycle after load_mode falls
    task automatic capture(output logic [31:0] stream, output int hi,
                           output int rdy_hi, output int ne_hi);
        stream = '0;
        hi     = 0;
        rdy_hi = 0;
        ne_hi  = 0;
        for (int i = 0; i < 40; i++) begin
            if (neuron_enable) ne_hi++;
            if (load_mode) begin
                stream = {stream[30:0], serial_data};
                hi++;
                if (cfg_if.cfg_ready) rdy_hi++;
            end else if (hi > 0) begin
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({load_mode, serial_data, neuron_enable, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {load_mode, serial_data, neuron_enable, busy, done, err});
        end
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_ready: got %b expected 1", cfg_if.cfg_ready);
        end
        rst_n = 1'b1;
        tick();
        // abort together with a valid byte: not accepted
        abort            = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 8'hFF;
        #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_cfg_ready: got %b expected 0", cfg_if.cfg_ready);
        end
        tick();
        abort            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_accept: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_normal();
        logic [31:0] s;
        int hi, rh, nh;
        send_bytes(32'hA53C0F81, 4, 1'b0, 8'h00);
        capture(s, hi, rh, nh);
        checks++;
        if (s !== 32'hA53C0F81) begin
            errors++;
            $display("FAIL normal_stream: got %h expected a53c0f81", s);
        end
        checks++;
        if (hi !== 32) begin
            errors++;
            $display("FAIL normal_load_len: got %0d expected 32", hi);
        end
        checks++;
        if ({load_mode, serial_data, busy} !== 3'b001) begin
            errors++;
            $display("FAIL normal_wait_pins: got %b expected 001", {load_mode, serial_data, busy});
        end
        repeat (5) tick();
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        checks++;
        if ({done, busy, err} !== 3'b100) begin
            errors++;
            $display("FAIL normal_done: done/busy/err got %b expected 100", {done, busy, err});
        end
        tick();
        checks++;
        if ({done, neuron_enable} !== 2'b00) begin
            errors++;
            $display("FAIL normal_done_pulse: done/ne got %b expected 00", {done, neuron_enable});
        end
        run_req = 1'b1;
        tick();
        checks++;
        if (neuron_enable !== 1'b1) begin
            errors++;
            $display("FAIL normal_enable: got %b expected 1", neuron_enable);
        end
    endtask

    task automatic test_reconfig();
        logic [31:0] s;
        int hi, rh, nh;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 8'h12;
        tick();
        cfg_if.cfg_data  = 8'h34;
        tick();
        checks++;
        if (neuron_enable !== 1'b0) begin
            errors++;
            $display("FAIL reconfig_enable_drop: got %b expected 0", neuron_enable);
        end
        cfg_if.cfg_data  = 8'h56;
        tick();
        cfg_if.cfg_data  = 8'h78;
        tick();
        cfg_if.cfg_valid = 1'b0;
        capture(s, hi, rh, nh);
        checks++;
        if (s !== 32'h12345678) begin
            errors++;
            $display("FAIL reconfig_stream: got %h expected 12345678", s);
        end
        checks++;
        if (nh !== 0) begin
            errors++;
            $display("FAIL reconfig_enable_low: high cycles got %0d expected 0", nh);
        end
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        checks++;
        if ({done, neuron_enable} !== 2'b10) begin
            errors++;
            $display("FAIL reconfig_done: done/ne got %b expected 10", {done, neuron_enable});
        end
        tick();
        checks++;
        if (neuron_enable !== 1'b1) begin
            errors++;
            $display("FAIL reconfig_enable_back: got %b expected 1", neuron_enable);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] s;
        int hi, rh, nh;
        int n;
        int done_cnt;
        send_bytes(32'hA53C0F81, 4, 1'b0, 8'h00);
        capture(s, hi, rh, nh);
        checks++;
        if (hi !== 32) begin
            errors++;
            $display("FAIL timeout_load_len: got %0d expected 32", hi);
        end
        done_cnt = 0;
        for (n = 1; n <= 80; n++) begin
            tick();
            if (done) done_cnt++;
            if (err) break;
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected 64", n);
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL timeout_no_done: got %0d expected 0", done_cnt);
        end
        tick();
        tick();
        checks++;
        if ({neuron_enable, busy} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_enable: ne/busy got %b expected 00", {neuron_enable, busy});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_sticky: got %b expected 1", err);
        end
        send_bytes(32'h9A000000, 1, 1'b0, 8'h00);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: got %b expected 0", err);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] s;
        int hi, rh, nh;
        run_req = 1'b0;
        send_bytes(32'hA53C0F81, 4, 1'b1, 8'h55);
        capture(s, hi, rh, nh);
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (s !== 32'hA53C0F81) begin
            errors++;
            $display("FAIL bp_stream: got %h expected a53c0f81", s);
        end
        checks++;
        if (rh !== 0) begin
            errors++;
            $display("FAIL bp_ready_low: ready cycles got %0d expected 0", rh);
        end
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got %b expected 1", done);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL bp_no_extra: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_abort();
        logic [31:0] s;
        int hi, rh, nh;
        int bad;
        run_req = 1'b1;
        send_bytes(32'hA53C0F81, 4, 1'b0, 8'h00);
        repeat (10) tick();
        checks++;
        if (load_mode !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_load: got %b expected 1", load_mode);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({load_mode, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_stop: load/busy got %b expected 00", {load_mode, busy});
        end
        params_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || neuron_enable || load_mode) bad++;
        end
        params_ready = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet: done/ne/load cycles got %0d expected 0", bad);
        end
        send_bytes(32'hC3E71824, 4, 1'b0, 8'h00);
        capture(s, hi, rh, nh);
        checks++;
        if (s !== 32'hC3E71824) begin
            errors++;
            $display("FAIL abort_reload_stream: got %h expected c3e71824", s);
        end
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        tick();
        checks++;
        if (neuron_enable !== 1'b1) begin
            errors++;
            $display("FAIL abort_reload_enable: got %b expected 1", neuron_enable);
        end
        run_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        int hi, rh, nh;
        send_bytes(32'h11220000, 2, 1'b0, 8'h00);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, load_mode, cfg_if.cfg_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_idle: busy/load/ready got %b expected 001",
                     {busy, load_mode, cfg_if.cfg_ready});
        end
        send_bytes(32'hDEADBEEF, 4, 1'b0, 8'h00);
        capture(s, hi, rh, nh);
        checks++;
        if (s !== 32'hDEADBEEF || hi !== 32) begin
            errors++;
            $display("FAIL rstmid_stream: got %h/%0d expected deadbeef/32", s, hi);
        end
        params_ready = 1'b1;
        tick();
        params_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: got %b expected 1", done);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        abort            = 1'b0;
        run_req          = 1'b0;
        params_ready     = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 8'h00;
        test_reset();
        test_normal();
        test_reconfig();
        test_timeout();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
